// File: rtl/cps_seq_sub.sv
// -----------------------------------------------------------------------------
// cps_seq_sub
//   Multi-cycle carry-propagate subtracter/adder. Computes a-b-c_in (mode=0)
//   or a+b+c_in (mode=1) over WIDTH bits, CHUNK bits per clock, LSB chunk
//   first. The borrow/carry is registered between chunks. Operands are
//   latched on the start edge. The final flags are published when the
//   operation completes.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per clock; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts an operation, no done)
//   start  request, sampled only in IDLE
//   mode   0 = subtract, 1 = add (latched at start)
//   a, b   operands (latched at start)
//   c_in   borrow-in / carry-in (latched at start)
//   busy   high while chunks are being processed
//   done   one-cycle pulse, result valid
//   s      result mod 2^WIDTH
//   c_out  borrow-out (sub) / carry-out (add)
//   ovf    two's-complement overflow
//   zero   s == 0
// -----------------------------------------------------------------------------
module cps_seq_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_chain;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;

    int               w_lo;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_res;
    logic             w_chain_nxt;
    logic [WIDTH-1:0] w_work_nxt;
    logic             w_ovf_nxt;
    logic             w_last;

    // One chunk of a ripple adder; the top bit is the carry out.
    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // One chunk of a ripple subtracter. The difference is taken over
    // CHUNK+1 bits. The top bit is set exactly when x < y + bin, which is
    // the borrow out.
    function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             bin);
        return {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
    endfunction

    // Chunk datapath: the slice selected by the index, merged into the working result
    always_comb begin
        w_lo        = int'(r_idx) * CHUNK;
        w_a_chunk   = r_a[w_lo +: CHUNK];
        w_b_chunk   = r_b[w_lo +: CHUNK];
        w_chunk_res = r_mode ? add_chunk(w_a_chunk, w_b_chunk, r_chain)
                             : sub_chunk(w_a_chunk, w_b_chunk, r_chain);
        w_chain_nxt = w_chunk_res[CHUNK];
        w_work_nxt  = r_work;
        w_work_nxt[w_lo +: CHUNK] = w_chunk_res[CHUNK-1:0];
        w_last      = (r_idx == LAST_IDX);
        // Overflow rule on operand/result sign bits: for subtract the operand
        // signs must differ, for add they must match, and the result sign
        // must differ from a's sign.
        w_ovf_nxt   = ((r_a[WIDTH-1] ^ r_b[WIDTH-1]) ^ r_mode) &
                      (w_work_nxt[WIDTH-1] ^ r_a[WIDTH-1]);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // Operand latch, chunk iteration and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_chain <= 1'b0;
            r_work  <= '0;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_chain <= c_in;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_work  <= w_work_nxt;
                    r_chain <= w_chain_nxt;
                    if (w_last) begin
                        // Last chunk: publish the completed result and flags.
                        r_idx   <= '0;
                        r_s     <= w_work_nxt;
                        r_c_out <= w_chain_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_zero  <= (w_work_nxt == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s     = r_s;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule

// File: tb/tb_cps_seq_sub.sv
// -----------------------------------------------------------------------------
// tb_cps_seq_sub
//   Bench for cps_seq_sub. It drives four instances: 16/4, 16/1, 16/16 and
//   8/2. The expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_cps_seq_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        mode, c_in;
    logic [15:0] a, b;
    logic        start0, start1, start2, start3;
    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic        cout0, cout1, cout2, cout3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic        zero0, zero1, zero2, zero3;
    logic [15:0] s0, s1, s2;
    logic [7:0]  s3;

    cps_seq_sub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode), .a(a), .b(b), .c_in(c_in),
        .busy(busy0), .done(done0), .s(s0), .c_out(cout0), .ovf(ovf0), .zero(zero0));
    cps_seq_sub #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b), .c_in(c_in),
        .busy(busy1), .done(done1), .s(s1), .c_out(cout1), .ovf(ovf1), .zero(zero1));
    cps_seq_sub #(.WIDTH(16), .CHUNK(16)) u2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .a(a), .b(b), .c_in(c_in),
        .busy(busy2), .done(done2), .s(s2), .c_out(cout2), .ovf(ovf2), .zero(zero2));
    cps_seq_sub #(.WIDTH(8), .CHUNK(2)) u3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .busy(busy3), .done(done3), .s(s3), .c_out(cout3), .ovf(ovf3), .zero(zero3));

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [15:0] prev_s [4];
    int          w_of   [4] = '{16, 16, 16, 8};
    int          n_of   [4] = '{4, 16, 1, 4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start0 = v;
            1: start1 = v;
            2: start2 = v;
            default: start3 = v;
        endcase
    endtask

    task automatic sample(input int inst, output logic bz, output logic dn, output logic co,
                          output logic ov, output logic zr, output logic [15:0] sv);
        case (inst)
            0: begin bz = busy0; dn = done0; co = cout0; ov = ovf0; zr = zero0; sv = s0; end
            1: begin bz = busy1; dn = done1; co = cout1; ov = ovf1; zr = zero1; sv = s1; end
            2: begin bz = busy2; dn = done2; co = cout2; ov = ovf2; zr = zero2; sv = s2; end
            default: begin bz = busy3; dn = done3; co = cout3; ov = ovf3; zr = zero3; sv = {8'h00, s3}; end
        endcase
    endtask

    // Reference: whole-word integer arithmetic; flags from the operand/result signs.
    task automatic ref_model(input int w, input logic md, input logic [15:0] av,
                             input logic [15:0] bv, input logic cin,
                             output logic [15:0] es, output logic ec,
                             output logic eo, output logic ez);
        longint mask, x, y, full;
        logic   sa, sb, ss;
        mask = (longint'(1) << w) - 1;
        x    = longint'(av) & mask;
        y    = longint'(bv) & mask;
        if (md) begin
            full = x + y + longint'(cin);
            ec   = (full > mask);
        end else begin
            full = x - y - longint'(cin);
            ec   = (x < y + longint'(cin));
        end
        es = 16'(full & mask);
        sa = x[w-1];
        sb = y[w-1];
        ss = es[w-1];
        eo = md ? ((sa == sb) && (ss != sa)) : ((sa != sb) && (ss != sa));
        ez = (es == 16'h0000);
    endtask

    task automatic run_op(input int inst, input logic md, input logic [15:0] av,
                          input logic [15:0] bv, input logic cin, input string tag);
        logic [15:0] es, sv;
        logic        ec, eo, ez, bz, dn, co, ov, zr;
        int          busy_cnt, done_at, nch;
        nch      = n_of[inst];
        busy_cnt = 0;
        done_at  = 0;
        ref_model(w_of[inst], md, av, bv, cin, es, ec, eo, ez);
        @(negedge clk);
        mode = md; a = av; b = bv; c_in = cin;
        set_start(inst, 1'b1);
        @(negedge clk);
        set_start(inst, 1'b0);
        // Inputs wander after the start edge; the latched copy must be used.
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); c_in = 1'($urandom);
        for (int c = 1; c <= nch + 8; c++) begin
            sample(inst, bz, dn, co, ov, zr, sv);
            if (bz) begin
                busy_cnt++;
                if (c == 1) check({tag, "_s_held"}, sv, prev_s[inst]);
            end
            if (dn) begin
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_latency"}, done_at, nch + 1);
        check({tag, "_busy_cycles"}, busy_cnt, nch);
        check({tag, "_s"}, sv, es);
        check({tag, "_c_out"}, co, ec);
        check({tag, "_ovf"}, ov, eo);
        check({tag, "_zero"}, zr, ez);
        @(negedge clk);
        sample(inst, bz, dn, co, ov, zr, sv);
        check({tag, "_done_1cyc"}, {bz, dn}, 2'b00);
        check({tag, "_s_kept"}, sv, es);
        prev_s[inst] = es;
    endtask

    initial begin
        logic [15:0] sv, sdone;
        logic        bz, dn, co, ov, zr;
        int          dcnt, bcnt;

        rst = 1'b1;
        start0 = 0; start1 = 0; start2 = 0; start3 = 0;
        mode = 0; c_in = 0; a = '0; b = '0;
        for (int i = 0; i < 4; i++) prev_s[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sample(i, bz, dn, co, ov, zr, sv);
            check("reset_outputs", {bz, dn, co, ov, zr, sv}, 21'h0);
        end
        rst = 1'b0;

        // Subtract basics, borrow, overflow and zero
        run_op(0, 1'b0, 16'h0005, 16'h0003, 1'b0, "t1_sub");
        run_op(0, 1'b0, 16'h0000, 16'h0001, 1'b0, "t2_borrow");
        run_op(0, 1'b0, 16'h8000, 16'h0001, 1'b0, "t2_ovf");
        run_op(0, 1'b0, 16'h1234, 16'h1233, 1'b1, "t2_zero");
        // Add mode
        run_op(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, "t3_add_ovf");
        run_op(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, "t3_add_carry");

        // Start pulsed mid-run with a changed operand is ignored
        @(negedge clk);
        mode = 0; a = 16'h00F0; b = 16'h000F; c_in = 0; start0 = 1'b1;
        dcnt = 0; bcnt = 0; sdone = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start0 = (c == 2);
            if (c == 2) a = 16'hFFFF;
            sample(0, bz, dn, co, ov, zr, sv);
            if (bz) begin
                bcnt++;
                if (c == 2) check("t4_s_held_in_run", sv, prev_s[0]);
            end
            if (dn) begin
                dcnt++;
                sdone = sv;
            end
        end
        start0 = 1'b0;
        check("t4_single_done", dcnt, 1);
        check("t4_busy_cycles", bcnt, 4);
        check("t4_s", sdone, 16'h00E1);
        prev_s[0] = 16'h00E1;

        // Reset mid-run aborts
        @(negedge clk);
        mode = 0; a = 16'h0005; b = 16'h0003; c_in = 0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample(0, bz, dn, co, ov, zr, sv);
        check("t5_reset_outputs", {bz, dn, co, ov, zr, sv}, 21'h0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sample(0, bz, dn, co, ov, zr, sv);
            if (dn) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        for (int i = 0; i < 4; i++) prev_s[i] = '0;
        run_op(0, 1'b0, 16'h0010, 16'h0001, 1'b0, "t5_after_rst");

        // Boundary cases on the other geometries
        run_op(1, 1'b1, 16'h7FFF, 16'h0000, 1'b1, "c1_add_ovf");
        run_op(2, 1'b0, 16'h8000, 16'h0000, 1'b1, "c16_sub_cin");
        run_op(3, 1'b1, 16'h00FF, 16'h0001, 1'b0, "w8_add_wrap");
        run_op(3, 1'b0, 16'h0080, 16'h0001, 1'b0, "w8_sub_ovf");

        // Randomized operations on all geometries, both modes
        for (int inst = 0; inst < 4; inst++) begin
            for (int i = 0; i < 10; i++) begin
                run_op(inst, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cps_seq_sub.md
Name: cps_seq_sub

Overview:
Parametrised, multi-cycle successor to the 16-bit carry-propagate subtracter. It computes a WIDTH-bit a-b-c_in, or a+b+c_in when add mode is selected. The operation runs as CHUNK bits per clock, LSB chunk first, with the borrow/carry registered between chunks. It sits behind a start/busy/done handshake and gives datapath users a narrow, area-cheap ALU with signed-overflow and zero flags.

Parameters:
WIDTH, 16, operand/result width in bits (>=2).
CHUNK, 4, bits processed per clock; WIDTH must be an exact multiple of CHUNK (1 <= CHUNK <= WIDTH).

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  1  0 = subtract (a-b-c_in), 1 = add (a+b+c_in); latched at start.
a  input  WIDTH  minuend / addend; latched at start.
b  input  WIDTH  subtrahend / addend; latched at start.
c_in  input  1  borrow-in (sub) / carry-in (add); latched at start.
busy  output  1  high while chunks are being processed.
done  output  1  one-cycle pulse, result valid.
s  output  WIDTH  result, mod 2^WIDTH.
c_out  output  1  borrow-out (sub) / carry-out (add).
ovf  output  1  two's-complement overflow.
zero  output  1  s == 0.

Behaviour:
- Reset: state IDLE; busy=0, done=0, s=0, c_out=0, ovf=0, zero=0; chunk index=0; working registers cleared. Reset takes priority over everything. Reset mid-operation aborts with no done pulse.
- N = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b, c_in and mode, sets the internal chain bit to c_in and index to 0, and moves to RUN.
- RUN: busy=1. Each edge computes chunk [index*CHUNK +: CHUNK] from the latched operands and the chain bit. It writes that chunk of the working result, updates the chain bit and increments index. After the N-th RUN edge, index wraps to 0 and the state moves to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then the state returns to IDLE.
- Result update: s, c_out, ovf and zero are updated on the edge entering DONE, from the completed working result and final chain bit. They hold their previous values throughout RUN and hold the new values until the next completion or reset.
- Latency: start sampled at edge k gives busy high during cycles k+1..k+N and done high in the cycle after edge k+N. Throughput is one operation per N+2 cycles.
- start is ignored in RUN and DONE; there is no queueing. Changes on a, b, c_in or mode after the start edge have no effect.
- Sub, per bit (full subtracter): d = a^b^bin; bout = (~(a^b)&bin) | (~a&b). c_out=1 iff a < b + c_in (unsigned).
- Add: standard full adder; c_out = carry out of the MSB.
- ovf, sub: a[MSB] != b[MSB] and s[MSB] != a[MSB].
- ovf, add: a[MSB] == b[MSB] and s[MSB] != a[MSB].
- ovf uses the latched operands.
- zero is computed from the final s only, independent of c_out.

Test Plan:
1. WIDTH=16, CHUNK=4, mode=0, a=0x0005, b=0x0003, c_in=0, start one cycle -> busy high 4 cycles, done pulse at the 5th cycle after start; s=0x0002, c_out=0, ovf=0, zero=0.
2. mode=0: a=0x0000, b=0x0001, c_in=0 -> s=0xFFFF, c_out=1, ovf=0. Then a=0x8000, b=0x0001 -> s=0x7FFF, c_out=0, ovf=1. Then a=0x1234, b=0x1233, c_in=1 -> s=0x0000, zero=1, c_out=0.
3. mode=1: a=0x7FFF, b=0x0001, c_in=0 -> s=0x8000, c_out=0, ovf=1. Then a=0xFFFF, b=0x0001 -> s=0x0000, c_out=1, ovf=0, zero=1.
4. Start a=0x00F0, b=0x000F, sub; in RUN cycle 2 pulse start and change a to 0xFFFF -> single done; s=0x00E1; no second operation. During RUN, s still shows the previous result.
5. Start an operation; assert rst in RUN cycle 2 -> next cycle all outputs 0, no done. A new start afterwards completes correctly with a=0x0010, b=0x0001 -> s=0x000F.
6. Random compare against a reference model: CHUNK=1 (done 17 cycles after start), CHUNK=16 (done 2 cycles after start), WIDTH=8/CHUNK=2 (done 5 cycles after start), both modes, all flags checked.
